// File: rtl/cmsdk_uart_stimulus_pkg.sv
// Shared definitions for the UART stimulus transmitter: serialiser state
// encodings and frame geometry constants.
package cmsdk_uart_stimulus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // 8N1: one start bit, eight data bits, one stop bit
  localparam int FRAME_BITS  = 10;
  localparam int DATA_BITS   = FRAME_BITS - 2;
  localparam int MIN_BAUDDIV = 16;

endpackage

// File: rtl/cmsdk_uart_stim_fifo.sv
// Byte-wide synchronous FIFO feeding the UART stimulus serialiser.
// The head entry is visible on dout without a read cycle; a push while full
// is refused even if a pop happens in the same cycle.
module cmsdk_uart_stim_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic [FIFO_AW:0] level,
  output logic             full
);

  localparam int               DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] ONE_L   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] ONE_P = {{(FIFO_AW-1){1'b0}}, 1'b1};

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (level == DEPTH_L);
  assign push_ok = push && !full;
  assign pop_ok  = pop && (level != '0);
  assign dout    = mem[rd_ptr];

  // Storage array; data only, so it carries no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and level bookkeeping; pointers wrap naturally modulo depth
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ONE_P;
      if (pop_ok)  rd_ptr <= rd_ptr + ONE_P;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/cmsdk_uart_stimulus.sv
// Bench-side UART transmitter: bytes pushed through a valid/ready port are
// queued in a FIFO and sent on TXD as 8N1 frames, BAUDDIV clocks per bit.
// Consecutive queued bytes go out back-to-back with no idle gap.
module cmsdk_uart_stimulus
  import cmsdk_uart_stimulus_pkg::*;
#(
  parameter int BAUDDIV = 16,
  parameter int FIFO_AW = 4
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [7:0]       DATA_IN,
  input  logic             DATA_VALID,
  output logic             DATA_READY,
  input  logic             ENABLE,
  output logic             TXD,
  output logic             BUSY,
  output logic [FIFO_AW:0] FIFO_LEVEL
);

  // Values below the supported minimum are clamped rather than rejected
  localparam int BAUD_EFF = (BAUDDIV < MIN_BAUDDIV) ? MIN_BAUDDIV : BAUDDIV;
  localparam int CNT_W    = $clog2(BAUD_EFF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  state_e          state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            last_cnt;
  logic            can_start;
  logic            pop;

  cmsdk_uart_stim_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESETn),
    .push  (DATA_VALID),
    .din   (DATA_IN),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (FIFO_LEVEL),
    .full  (fifo_full)
  );

  assign DATA_READY = !fifo_full;
  assign last_cnt   = (baud_cnt == CNT_LAST);
  // Uses the registered level, so a same-cycle push cannot start a frame
  assign can_start  = ENABLE && (FIFO_LEVEL != '0);

  // Pop the head when a frame is about to start, from idle or at end of stop
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE: pop = can_start;
      ST_STOP: pop = last_cnt && can_start;
      default: pop = 1'b0;
    endcase
  end

  // Load the byte to send whenever a frame starts
  always_ff @(posedge CLK) begin
    if (pop) shift <= fifo_dout;
  end

  // Serialiser: start bit, eight data bits LSB first, stop bit
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      TXD      <= 1'b1;
      BUSY     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            state <= ST_START;
            TXD   <= 1'b0;
            BUSY  <= 1'b1;
          end
        end
        ST_START: begin
          if (last_cnt) begin
            state    <= ST_DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            TXD      <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (last_cnt) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              state <= ST_STOP;
              TXD   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TXD     <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (last_cnt) begin
            baud_cnt <= '0;
            if (pop) begin
              state <= ST_START;
              TXD   <= 1'b0;
            end else begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          TXD      <= 1'b1;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmsdk_uart_stimulus.sv
// Directed bench for cmsdk_uart_stimulus (BAUDDIV=16, 16-entry FIFO).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cmsdk_uart_stimulus;

  localparam int BAUD = 16;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic [7:0] DATA_IN;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic       ENABLE;
  logic       TXD;
  logic       BUSY;
  logic [4:0] FIFO_LEVEL;

  int pass_cnt = 0;
  int total_cnt = 0;

  cmsdk_uart_stimulus #(
    .BAUDDIV (BAUD),
    .FIFO_AW (4)
  ) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .DATA_IN    (DATA_IN),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .ENABLE     (ENABLE),
    .TXD        (TXD),
    .BUSY       (BUSY),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at the falling edge just after TXD dropped for the start bit.
  // Every cycle of every bit is compared; returns at cycle 160 of the frame.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic exp_bit;
    logic seen;
    logic busy_seen;
    busy_seen = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      seen = exp_bit;
      for (int c = 0; c < BAUD; c++) begin
        if (TXD !== exp_bit) seen = TXD;
        if (BUSY !== 1'b1) busy_seen = BUSY;
        step();
      end
      check($sformatf("%s_bit%0d", tag, k), {31'd0, seen}, {31'd0, exp_bit});
    end
    check($sformatf("%s_busy", tag), {31'd0, busy_seen}, 32'd1);
  endtask

  initial begin
    logic quiet;
    RESETn = 1'b0;
    DATA_IN = 8'h00;
    DATA_VALID = 1'b0;
    ENABLE = 1'b1;
    step(2);
    RESETn = 1'b1;
    check("rst_txd",   {31'd0, TXD}, 32'd1);
    check("rst_busy",  {31'd0, BUSY}, 32'd0);
    check("rst_ready", {31'd0, DATA_READY}, 32'd1);
    check("rst_level", {27'd0, FIFO_LEVEL}, 32'd0);

    // Single byte 0x55
    DATA_IN = 8'h55; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    check("t1_level_after_push", {27'd0, FIFO_LEVEL}, 32'd1);
    check("t1_txd_before_pop",   {31'd0, TXD}, 32'd1);
    step();
    check("t1_txd_fall",    {31'd0, TXD}, 32'd0);
    check("t1_level_popped", {27'd0, FIFO_LEVEL}, 32'd0);
    check_frame(8'h55, "t1");
    check("t1_idle_busy", {31'd0, BUSY}, 32'd0);
    check("t1_idle_txd",  {31'd0, TXD}, 32'd1);

    // Back-to-back 0xA3, 0x0F
    DATA_IN = 8'hA3; DATA_VALID = 1'b1;
    step();
    DATA_IN = 8'h0F;
    step();
    DATA_VALID = 1'b0;
    check("t2_level", {27'd0, FIFO_LEVEL}, 32'd1);
    check_frame(8'hA3, "t2a");
    check_frame(8'h0F, "t2b");
    check("t2_idle_busy", {31'd0, BUSY}, 32'd0);

    // FIFO full with ENABLE low
    ENABLE = 1'b0;
    for (int i = 0; i < 15; i++) begin
      DATA_IN = 8'(i); DATA_VALID = 1'b1;
      step();
    end
    check("t3_ready_at15", {31'd0, DATA_READY}, 32'd1);
    check("t3_level_at15", {27'd0, FIFO_LEVEL}, 32'd15);
    DATA_IN = 8'h0F;
    step();
    check("t3_ready_full", {31'd0, DATA_READY}, 32'd0);
    check("t3_level_full", {27'd0, FIFO_LEVEL}, 32'd16);
    DATA_IN = 8'h10;
    step();
    DATA_VALID = 1'b0;
    check("t3_level_refused", {27'd0, FIFO_LEVEL}, 32'd16);
    check("t3_txd_disabled",  {31'd0, TXD}, 32'd1);
    ENABLE = 1'b1;
    step();
    check("t3_level_first_pop", {27'd0, FIFO_LEVEL}, 32'd15);
    for (int i = 0; i < 16; i++) check_frame(8'(i), $sformatf("t3f%0d", i));
    check("t3_done_busy",  {31'd0, BUSY}, 32'd0);
    check("t3_done_level", {27'd0, FIFO_LEVEL}, 32'd0);

    // ENABLE drop mid-frame: 0x3C in flight, 0x81 and 0x7E queued
    DATA_IN = 8'h3C; DATA_VALID = 1'b1;
    step();
    DATA_IN = 8'h81;
    step();                       // frame cycle 0
    check("t4_txd_start", {31'd0, TXD}, 32'd0);
    DATA_IN = 8'h7E;
    step();                       // cycle 1
    DATA_VALID = 1'b0;
    check("t4_level", {27'd0, FIFO_LEVEL}, 32'd2);
    step(23);                     // cycle 24: data bit 0 of 0x3C
    check("t4_bit0", {31'd0, TXD}, 32'd0);
    step(16);                     // cycle 40
    ENABLE = 1'b0;
    step(16);                     // cycle 56: data bit 2
    check("t4_bit2", {31'd0, TXD}, 32'd1);
    step(103);                    // cycle 159: last stop cycle
    check("t4_stop_busy", {31'd0, BUSY}, 32'd1);
    check("t4_stop_txd",  {31'd0, TXD}, 32'd1);
    step();                       // cycle 160
    check("t4_end_busy", {31'd0, BUSY}, 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (TXD !== 1'b1 || BUSY !== 1'b0) quiet = 1'b0;
      step();
    end
    check("t4_held_idle", {31'd0, quiet}, 32'd1);
    check("t4_level_kept", {27'd0, FIFO_LEVEL}, 32'd2);
    ENABLE = 1'b1;
    step();
    check("t4_resume_level", {27'd0, FIFO_LEVEL}, 32'd1);
    check_frame(8'h81, "t4a");
    check_frame(8'h7E, "t4b");
    check("t4_done_busy", {31'd0, BUSY}, 32'd0);

    // Reset mid-frame with 3 bytes queued
    DATA_IN = 8'h11; DATA_VALID = 1'b1;
    step();
    DATA_IN = 8'h22;
    step();                       // cycle 0
    DATA_IN = 8'h33;
    step();
    DATA_IN = 8'h44;
    step();                       // cycle 2
    DATA_VALID = 1'b0;
    check("t5_level", {27'd0, FIFO_LEVEL}, 32'd3);
    step(68);                     // cycle 70
    RESETn = 1'b0;
    step();
    RESETn = 1'b1;
    check("t5_txd",   {31'd0, TXD}, 32'd1);
    check("t5_busy",  {31'd0, BUSY}, 32'd0);
    check("t5_level_flushed", {27'd0, FIFO_LEVEL}, 32'd0);
    check("t5_ready", {31'd0, DATA_READY}, 32'd1);
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (TXD !== 1'b1 || BUSY !== 1'b0) quiet = 1'b0;
      step();
    end
    check("t5_no_frames", {31'd0, quiet}, 32'd1);

    // Push in the exact cycle STOP completes, one byte already queued
    DATA_IN = 8'hC5; DATA_VALID = 1'b1;
    step();
    DATA_IN = 8'h5A;
    step();                       // cycle 0
    DATA_VALID = 1'b0;
    step(159);                    // cycle 159
    check("t6_stop_txd", {31'd0, TXD}, 32'd1);
    DATA_IN = 8'h99; DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    check("t6_level_same", {27'd0, FIFO_LEVEL}, 32'd1);
    check("t6_no_gap", {31'd0, TXD}, 32'd0);
    check_frame(8'h5A, "t6a");
    check_frame(8'h99, "t6b");
    check("t6_done_busy",  {31'd0, BUSY}, 32'd0);
    check("t6_done_level", {27'd0, FIFO_LEVEL}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cmsdk_uart_stimulus.md
Name: cmsdk_uart_stimulus

Overview:
Testbench-side UART transmitter. It drives serial characters into the MCU UART RXD pin (P1[0], UART0 RXD), in the opposite direction to the UART capture device. Bytes are queued through a valid/ready push interface into an internal FIFO and serialised as 8N1 frames at a fixed clocks-per-bit rate. It is clocked from the same PCLK as the capture device, so a bench loopback into the capture device decodes the frames.

Parameters:
BAUDDIV, 16, clocks per serial bit; legal range 16..65535; must match the MCU UART BAUDDIV setting.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
CLK  input  1  clock (PCLK).
RESETn  input  1  synchronous active-low reset.
DATA_IN  input  8  byte to transmit.
DATA_VALID  input  1  push request.
DATA_READY  output  1  FIFO can accept; push occurs when DATA_VALID & DATA_READY at a rising edge.
ENABLE  input  1  high = frames may start; low = finish the current frame, then hold idle.
TXD  output  1  serial output; idle high.
BUSY  output  1  high while a frame is in progress.
FIFO_LEVEL  output  FIFO_AW+1  number of queued bytes, excluding the byte in flight.

Behaviour:
- Reset: one clock with RESETn low is sufficient (sampled on a CLK edge), then the following values hold:
  - TXD=1, BUSY=0, DATA_READY=1, FIFO_LEVEL=0.
  - FIFO is flushed; bit counter = 0; baud counter = 0; state = IDLE.
- Reset mid-frame: the frame is aborted with no partial stop bit; TXD=1 after the reset edge.
- All outputs are registered, except DATA_READY = (FIFO_LEVEL != 2**FIFO_AW), which is combinational from the registered level.
- FIFO:
  - Push and pop in the same cycle leave the level unchanged.
  - When full, DATA_READY=0 and a push is refused, even if a pop happens in the same cycle.
  - Pointers wrap modulo depth; the level counter is one bit wider than the pointers.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: if ENABLE && level!=0, pop the head into the shift register; next state START; TXD=0; BUSY=1; baud counter=0.
  - START: hold TXD=0 for BAUDDIV cycles. At count BAUDDIV-1, go to DATA; TXD=shift[0]; bit index=0.
  - DATA: each bit is held BAUDDIV cycles, LSB first. After bit 7 completes, go to STOP; TXD=1.
  - STOP: hold TXD=1 for BAUDDIV cycles. At the end, if ENABLE && level!=0, pop and go directly to START (back-to-back, no idle gap); else go to IDLE with BUSY=0.
- Latency: byte accepted at edge N into an empty FIFO while IDLE and enabled → level=1 after N, pop at N+1, TXD falls after edge N+1.
- Frame length is exactly 10*BAUDDIV cycles.
- ENABLE deassert mid-frame: the current frame completes unchanged; the FIFO contents are retained. Re-assert resumes from IDLE on the next cycle.
- Pop condition uses the level registered before any same-cycle push, so a push in the last STOP cycle is not seen until the next cycle. In that case the FIFO was empty, so the machine returns to IDLE for one cycle.
- Baud counter width = clog2(BAUDDIV); it resets to 0 on every state transition.

Decomposition:
- Shared include (cmsdk_uart_stimulus_defs.v): state encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3; frame bit count (10); minimum BAUDDIV (16).
- One sub-module: cmsdk_uart_stim_fifo. It is a parameterised synchronous FIFO (FIFO_AW, width 8) with push, pop, dout, level and full.
- The serialiser FSM stays in the top module.

Test Plan:
- Single byte, BAUDDIV=16: push 0x55 while idle → TXD low after the next edge, then the bits 0,1,0,1,0,1,0,1,0,1, each held 16 cycles; BUSY high for 160 cycles; level returns to 0.
- Back-to-back: push 0xA3 then 0x0F in consecutive cycles → two 160-cycle frames with no idle gap. Loopback into the capture device decodes 0xA3 and then 0x0F.
- FIFO full: ENABLE=0, push 17 bytes 0x00..0x10 → DATA_READY=0 after the 16th push and FIFO_LEVEL=16; byte 0x10 is not accepted. Set ENABLE=1 → bytes 0x00..0x0F are sent in order.
- ENABLE drop mid-frame: deassert ENABLE at cycle 40 of a 0x3C frame with 2 bytes queued → the frame completes at cycle 160, then TXD stays 1 and level=2. Re-assert → the next frame starts 1 cycle later.
- Reset mid-frame: RESETn low for 1 cycle at cycle 70 of a frame with 3 bytes queued → after the reset edge TXD=1, BUSY=0, FIFO_LEVEL=0, DATA_READY=1, and no further frames are sent.
- Simultaneous push/pop: with one byte queued, push a byte in the exact cycle STOP completes → the level stays 1 and the next frame starts without a gap.
